// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, round constants, FSM state type and GF(2^8) helpers
package aes_pkg;
    localparam int TEXT_WIDTH = 128;
    localparam int KEY_WIDTH  = 128;

    // Indexed by round number 1..10; unused slots are zero so any 4-bit index is safe.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h36, 8'h1b, 8'h80,
        8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
    };

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, DONE} aes_state_e;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_dec_key_sched.sv
// rtl/aes_dec_key_sched.sv - AES-128 round-key register with forward and inverse single-round steps
module aes_dec_key_sched
    import aes_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 fwd_i,
    input  logic                 inv_i,
    input  logic [3:0]           rcon_idx_i,
    output logic [KEY_WIDTH-1:0] key_o,
    output logic [KEY_WIDTH-1:0] key_inv_o
);
    logic [KEY_WIDTH-1:0] key_q, key_d, key_fwd;
    logic [31:0] w0, w1, w2, w3, f0, f1, f2, f3, i0, i1, i2, i3, rc;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    assign {w0, w1, w2, w3} = key_q;
    assign rc = {RCON[rcon_idx_i], 24'h000000};

    assign f0 = w0 ^ sub_rot(w3) ^ rc;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    // Undo the forward step: recover the last word first, since w0 depends on it.
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ sub_rot(i3) ^ rc;

    assign key_fwd   = {f0, f1, f2, f3};
    assign key_inv_o = {i0, i1, i2, i3};
    assign key_o     = key_q;

    always_comb begin
        key_d = key_q;
        if (load_i)     key_d = key_i;
        else if (fwd_i) key_d = key_fwd;
        else if (inv_i) key_d = key_inv_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) key_q <= '0;
        else       key_q <= key_d;
    end
endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 decryptor, one round per cycle
// Optional AES_DEC_KEY_CACHE_EN keeps the last key's rk10 so a repeated key skips expansion.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [TEXT_WIDTH-1:0] ciphertext_i,
    input  logic [KEY_WIDTH-1:0]  key_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [TEXT_WIDTH-1:0] plaintext_o
);
    if (NR != 10) begin : g_nr_unsupported
        $error("aes_decrypt supports only NR=10");
    end

    aes_state_e            fsm_q, fsm_d;
    logic [3:0]            cnt_q, cnt_d, rcon_idx;
    logic [TEXT_WIDTH-1:0] state_q, state_d, pt_q, pt_d;
    logic                  done_q, done_d;
    logic                  ks_load, ks_fwd, ks_inv, cache_hit;
    logic [KEY_WIDTH-1:0]  ks_key, rk_cnt, ks_load_val;
    logic [TEXT_WIDTH-1:0] isb, ark, imc, round_out;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
                gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
                gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
                gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
    endfunction

    // The inverse key step consumes Rcon of the round being undone (cnt+1).
    assign rcon_idx = (fsm_q == ROUND) ? cnt_q + 4'd1 : cnt_q;

    aes_dec_key_sched u_key_sched (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ks_load),
        .key_i      (ks_load_val),
        .fwd_i      (ks_fwd),
        .inv_i      (ks_inv),
        .rcon_idx_i (rcon_idx),
        .key_o      (ks_key),
        .key_inv_o  (rk_cnt)
    );

    // Byte b = r + 4c sits at bits [127-8b -: 8]; row r rotates right by r.
    always_comb begin
        isb = '0;
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127 - 8*(4*c + r) -: 8] = inv_sbox(state_q[127 - 8*(4*((c - r) & 3) + r) -: 8]);
            end
        end
        ark = isb ^ rk_cnt;
        for (int c = 0; c < 4; c++) begin
            imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
        round_out = (cnt_q == 4'd0) ? ark : imc;
    end

`ifdef AES_DEC_KEY_CACHE_EN
    logic [KEY_WIDTH-1:0] cache_key_q, cache_key_d, cache_rk_q, cache_rk_d;
    logic                 cache_vld_q, cache_vld_d;

    assign cache_hit   = cache_vld_q && (key_i == cache_key_q);
    assign ks_load_val = cache_hit ? cache_rk_q : key_i;

    always_comb begin
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
        if (fsm_q == IDLE && start_i && !cache_hit) begin
            cache_key_d = key_i;
            cache_vld_d = 1'b0;
        end
        if (fsm_q == ADDK) begin
            cache_rk_d  = ks_key;
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign ks_load_val = key_i;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        ks_load = 1'b0;
        ks_fwd  = 1'b0;
        ks_inv  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ciphertext_i;
                    ks_load = 1'b1;
                    cnt_d   = 4'd1;
                    fsm_d   = cache_hit ? ADDK : KEYEXP;
                end
            end
            KEYEXP: begin
                ks_fwd = 1'b1;
                if (cnt_q == 4'd10) fsm_d = ADDK;
                else                cnt_d = cnt_q + 4'd1;
            end
            ADDK: begin
                state_d = state_q ^ ks_key;
                cnt_d   = 4'd9;
                fsm_d   = ROUND;
            end
            ROUND: begin
                ks_inv  = 1'b1;
                state_d = round_out;
                if (cnt_q == 4'd0) fsm_d = DONE;
                else               cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                pt_d   = state_q;
                done_d = 1'b1;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign busy_o      = (fsm_q != IDLE);
    assign done_o      = done_q;
    assign plaintext_o = pt_q;
endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - directed FIPS-197 vector bench for aes_decrypt
module tb_aes_decrypt;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 12;
`else
    localparam int HIT_LAT = 22;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         busy, done;
    logic [127:0] pt;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    aes_decrypt #(.NR(10)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .ciphertext_i (ct),
        .key_i        (key),
        .busy_o       (busy),
        .done_o       (done),
        .plaintext_o  (pt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic run_op(input logic [127:0] c, input logic [127:0] k,
                          output logic [127:0] p, output int lat, output logic busy_acc);
        @(negedge clk);
        ct = c;
        key = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_acc = busy;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        p = pt;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pt !== 128'h0) begin errors++; $display("FAIL reset_pt got %h want 0", pt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_c1;
        logic [127:0] p;
        int lat;
        logic b;
        run_op(C1_CT, C1_KEY, p, lat, b);
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL c1_busy_after_accept got %b want 1", b); end
        checks++; if (p !== C1_PT) begin errors++; $display("FAIL c1_plaintext got %h want %h", p, C1_PT); end
        checks++; if (lat != 22) begin errors++; $display("FAIL c1_latency got %0d want 22", lat); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL c1_done_width got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL c1_busy_after_done got %b want 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pt !== C1_PT) begin errors++; $display("FAIL c1_pt_hold got %h want %h", pt, C1_PT); end
    endtask

    task automatic test_appendix_b;
        logic [127:0] p;
        int lat;
        logic b;
        run_op(B_CT, B_KEY, p, lat, b);
        checks++; if (p !== B_PT) begin errors++; $display("FAIL b_plaintext got %h want %h", p, B_PT); end
        checks++; if (lat != 22) begin errors++; $display("FAIL b_latency got %0d want 22", lat); end
    endtask

    task automatic test_repeat_key;
        logic [127:0] p;
        int lat;
        logic b;
        run_op(C1_CT, C1_KEY, p, lat, b);
        checks++; if (lat != 22) begin errors++; $display("FAIL rep_first_latency got %0d want 22", lat); end
        run_op(C1_CT, C1_KEY, p, lat, b);
        checks++; if (p !== C1_PT) begin errors++; $display("FAIL rep_second_pt got %h want %h", p, C1_PT); end
        checks++; if (lat != HIT_LAT) begin errors++; $display("FAIL rep_second_latency got %0d want %0d", lat, HIT_LAT); end
        run_op(B_CT, B_KEY, p, lat, b);
        checks++; if (p !== B_PT) begin errors++; $display("FAIL rep_b_pt got %h want %h", p, B_PT); end
        checks++; if (lat != 22) begin errors++; $display("FAIL rep_b_latency got %0d want 22", lat); end
    endtask

    task automatic test_start_ignored;
        logic [127:0] p;
        int lat, dones;
        @(negedge clk);
        ct = C1_CT;
        key = C1_KEY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        dones = 0;
        p = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 15) begin
                ct = B_CT;
                key = B_KEY;
                start = 1'b1;
            end
            if (n == 16) start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    p = pt;
                end
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", dones); end
        checks++; if (p !== C1_PT) begin errors++; $display("FAIL ign_plaintext got %h want %h", p, C1_PT); end
        checks++; if (lat != 22) begin errors++; $display("FAIL ign_latency got %0d want 22", lat); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic saw_done;
        @(negedge clk);
        ct = C1_CT;
        key = C1_KEY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (saw_done !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_done got %b/%b want 0/0", saw_done, done); end
        checks++; if (pt !== 128'h0) begin errors++; $display("FAIL mid_pt got %h want 0", pt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        rst = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat != 22) begin errors++; $display("FAIL mid_rerun_latency got %0d want 22", lat); end
        checks++; if (pt !== C1_PT) begin errors++; $display("FAIL mid_rerun_pt got %h want %h", pt, C1_PT); end
    endtask

    task automatic test_back_to_back;
        logic [127:0] cts [3];
        logic [127:0] keys [3];
        logic [127:0] pts [3];
        int k, last_cyc;
        cts[0] = B_CT;  keys[0] = B_KEY;  pts[0] = B_PT;
        cts[1] = C1_CT; keys[1] = C1_KEY; pts[1] = C1_PT;
        cts[2] = B_CT;  keys[2] = B_KEY;  pts[2] = B_PT;
        @(negedge clk);
        ct = cts[0];
        key = keys[0];
        start = 1'b1;
        k = 0;
        last_cyc = 0;
        for (int n = 0; n < 120 && k < 3; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                checks++; if (pt !== pts[k]) begin errors++; $display("FAIL b2b_pt%0d got %h want %h", k, pt, pts[k]); end
                if (k > 0) begin
                    checks++; if (cyc - last_cyc != 23) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 23", k, cyc - last_cyc); end
                end
                last_cyc = cyc;
                k++;
                if (k < 3) begin
                    ct = cts[k];
                    key = keys[k];
                end
            end
        end
        start = 1'b0;
        checks++; if (k != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", k); end
    endtask

    initial begin
        test_reset();
        test_c1();
        test_appendix_b();
        test_repeat_key();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
